// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks a fixed-length program through
// FETCH/DECODE/EXEC/WB, decodes the held instruction and counts retirements.
module core_sequencer #(
  parameter int PROG_VALUE = 3,
  parameter int ADDR_W     = (PROG_VALUE > 1) ? $clog2(PROG_VALUE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [7:0]        instr,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        opcode,
  output logic [1:0]        rs1,
  output logic [1:0]        rs2,
  output logic [1:0]        rd,
  output logic              alu_en,
  output logic              rf_we,
  output logic              busy,
  output logic              done,
  output logic [7:0]        retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_VALUE - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [7:0]        ir;
  logic [7:0]        ir_next;
  logic [7:0]        retired_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      retired <= retired_next;
    end
  end

  // Next-state logic and Moore outputs; outputs depend only on state and ir.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    retired_next = retired;
    alu_en       = 1'b0;
    rf_we        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next   = FETCH;
          pc_next      = '0;
          retired_next = '0;
        end
      end
      FETCH: begin
        busy = 1'b1;
        if (!pause) begin
          ir_next    = instr;
          state_next = DECODE;
        end
      end
      DECODE: begin
        busy       = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        busy       = 1'b1;
        alu_en     = 1'b1;
        state_next = WB;
      end
      WB: begin
        busy   = 1'b1;
        alu_en = 1'b1;
        rf_we  = 1'b1;
        // Counter sticks at 255 so long programs never wrap back to small values.
        if (retired != 8'hFF) begin
          retired_next = retired + 8'd1;
        end
        if (pc == LAST_PC) begin
          state_next = DONE;
          pc_next    = '0;
        end else begin
          state_next = FETCH;
          pc_next    = pc + ADDR_W'(1);
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign opcode = ir[1:0];
  assign rs1    = ir[3:2];
  assign rs2    = ir[5:4];
  assign rd     = ir[7:6];

endmodule
